// File: rtl/slave_fifo_pkg.sv
// Shared types and helpers for the packet-mode slave FIFO.
package slave_fifo_pkg;

  localparam int unsigned DefaultPlenW = 3;

  typedef enum logic [1:0] {StIdle, StReq, StSend} slv_state_t;

  // Packet length in words: 4 << code, saturated at the buffer depth.
  function automatic int unsigned pkglen_decode(input int unsigned code, input int unsigned aw);
    int unsigned depth;
    int unsigned len;
    depth = 32'd1 << aw;
    if (code >= 30) return depth;
    len = 32'd4 << code;
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/slave_fifo_ram.sv
// Storage array for the slave FIFO: one synchronous write port, one asynchronous read port.
module slave_fifo_ram #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 6
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/slave_fifo_pkt.sv
// Packet-mode slave FIFO: buffers channel words and streams one full packet per arbiter grant.
module slave_fifo_pkt
  import slave_fifo_pkg::*;
#(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 6,
  parameter int unsigned PLEN_W = DefaultPlenW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DW-1:0]     chx_data_i,
  input  logic              chx_valid_i,
  output logic              chx_ready_o,
  input  logic              slvx_en_i,
  input  logic [PLEN_W-1:0] slvx_pkglen_i,
  input  logic              slvx_flush_i,
  output logic [AW:0]       slvx_margin_o,
  input  logic              a2sx_ack_i,
  output logic              slvx_req_o,
  output logic [DW-1:0]     slvx_data_o,
  output logic              slvx_valid_o,
  output logic              slvx_last_o
);

  localparam int unsigned PtrW  = AW + 1;
  localparam logic [AW:0] Depth = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] One   = {{AW{1'b0}}, 1'b1};

  slv_state_t  state_q;
  logic [AW:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [AW:0] count_d, len_dec, len_q, beat_q, margin_q;
  logic        req_q, valid_q, last_q;
  logic        full, push, pop;
  logic [DW-1:0] rd_data;

  assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign chx_ready_o = slvx_en_i & ~full & ~slvx_flush_i & ~rst_i;
  assign push        = chx_valid_i & chx_ready_o;
  assign pop         = valid_q;

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  assign count_d  = wr_ptr_d - rd_ptr_d;
  assign len_dec  = PtrW'(pkglen_decode(32'(slvx_pkglen_i), AW));

  slave_fifo_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (chx_data_i),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_data)
  );

  // Flush shares the reset path; reset and flush both clear every register.
  always_ff @(posedge clk_i) begin
    if (rst_i || slvx_flush_i) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      margin_q <= Depth;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      margin_q <= Depth - count_d;
      unique case (state_q)
        StIdle: begin
          if (slvx_en_i && (count_d >= len_dec)) begin
            state_q <= StReq;
            req_q   <= 1'b1;
            len_q   <= len_dec;
          end
        end
        StReq: begin
          if (a2sx_ack_i) begin
            state_q <= StSend;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            beat_q  <= One;
            last_q  <= (len_q == One);
          end
        end
        StSend: begin
          if (last_q) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            beat_q  <= '0;
            // Enough data already buffered: re-request without passing through idle.
            if (slvx_en_i && (count_d >= len_dec)) begin
              state_q <= StReq;
              req_q   <= 1'b1;
              len_q   <= len_dec;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            beat_q <= beat_q + One;
            last_q <= ((beat_q + One) == len_q);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign slvx_margin_o = margin_q;
  assign slvx_req_o    = req_q;
  assign slvx_valid_o  = valid_q;
  assign slvx_last_o   = last_q;
  assign slvx_data_o   = valid_q ? rd_data : '0;

endmodule

// File: tb/tb_slave_fifo_pkt.sv
// Directed/randomized bench for slave_fifo_pkt with a queue-based reference model.
module tb_slave_fifo_pkt;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] chx_data;
  logic        chx_valid;
  logic        chx_ready;
  logic        en;
  logic [2:0]  pkglen;
  logic        flush;
  logic [6:0]  margin;
  logic        ack;
  logic        req;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rlast;

  int total = 0;
  int bad   = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  slave_fifo_pkt #(
    .DW     (32),
    .AW     (6),
    .PLEN_W (3)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .chx_data_i    (chx_data),
    .chx_valid_i   (chx_valid),
    .chx_ready_o   (chx_ready),
    .slvx_en_i     (en),
    .slvx_pkglen_i (pkglen),
    .slvx_flush_i  (flush),
    .slvx_margin_o (margin),
    .a2sx_ack_i    (ack),
    .slvx_req_o    (req),
    .slvx_data_o   (rdata),
    .slvx_valid_o  (rvalid),
    .slvx_last_o   (rlast)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    chk("rst_ready", 64'(chx_ready), 64'(0));
    chk("rst_req", 64'(req), 64'(0));
    chk("rst_valid", 64'(rvalid), 64'(0));
    chk("rst_last", 64'(rlast), 64'(0));
    chk("rst_data", 64'(rdata), 64'(0));
    chk("rst_margin", 64'(margin), 64'(64));
    rst = 1'b0;
    q.delete();
  endtask

  // Offer n words; the model accepts a word only when enabled and not holding 64.
  task automatic push_words(input int n, input bit seq);
    logic [31:0] d;
    bit rdy;
    for (int i = 0; i < n; i++) begin
      d = seq ? 32'(10 * (i + 1)) : $urandom;
      chx_valid = 1'b1;
      chx_data  = d;
      #1;
      rdy = en && (q.size() < 64);
      chk("push_ready", 64'(chx_ready), 64'(rdy));
      tick();
      if (rdy) q.push_back(d);
    end
    chx_valid = 1'b0;
  endtask

  // Grant the pending request and check every beat; optionally write alongside.
  task automatic run_burst(input int len, input bit wr, input int abort_at);
    logic [31:0] d;
    logic [31:0] head;
    bit rdy;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    for (int b = 1; b <= len; b++) begin
      d = $urandom;
      chx_valid = wr;
      chx_data  = d;
      #1;
      head = (q.size() > 0) ? q[0] : 32'hdead_beef;
      chk("beat_valid", 64'(rvalid), 64'(1));
      chk("beat_data", 64'(rdata), 64'(head));
      chk("beat_last", 64'(rlast), 64'(b == len));
      chk("beat_req", 64'(req), 64'(0));
      chk("beat_margin", 64'(margin), 64'(64 - q.size()));
      if (b == abort_at) begin
        chx_valid = 1'b0;
        return;
      end
      rdy = en && (q.size() < 64);
      if (wr) chk("beat_ready", 64'(chx_ready), 64'(rdy));
      tick();
      head = q.pop_front();
      if (wr && rdy) q.push_back(d);
    end
    chx_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; chx_data = '0; chx_valid = 1'b0; en = 1'b0;
    pkglen = 3'd3; flush = 1'b0; ack = 1'b0;
    tick();
    do_reset();

    // 1: 32 sequential words with len 32 raise the request on the final push
    en = 1'b1;
    pkglen = 3'd3;
    push_words(31, 1'b1);
    chk("t1_req_early", 64'(req), 64'(0));
    q.delete();
    for (int i = 1; i <= 31; i++) q.push_back(32'(10 * i));
    chx_valid = 1'b1; chx_data = 32'd320;
    #1;
    chk("t1_ready32", 64'(chx_ready), 64'(1));
    tick();
    chx_valid = 1'b0;
    q.push_back(32'd320);
    chk("t1_req", 64'(req), 64'(1));
    chk("t1_margin", 64'(margin), 64'(32));

    // 2: stream the packet back in order
    run_burst(32, 1'b0, 0);
    chk("t2_valid_end", 64'(rvalid), 64'(0));
    chk("t2_req", 64'(req), 64'(0));
    chk("t2_margin", 64'(margin), 64'(64));

    // 3: overfill, then a grant frees space after the first pop
    push_words(66, 1'b0);
    chk("t3_count", 64'(q.size()), 64'(64));
    chk("t3_margin", 64'(margin), 64'(0));
    chk("t3_ready", 64'(chx_ready), 64'(0));
    chk("t3_req", 64'(req), 64'(1));
    run_burst(32, 1'b1, 0);
    chk("t3_rereq", 64'(req), 64'(1));
    run_burst(32, 1'b0, 0);
    chk("t3_idle", 64'(req), 64'(0));

    // 4: full-depth packet with concurrent writes across pointer wrap
    pkglen = 3'd4;
    push_words(64 - q.size(), 1'b0);
    chk("t4_req64", 64'(req), 64'(1));
    run_burst(64, 1'b1, 0);
    chk("t4_req_after", 64'(req), 64'(0));
    pkglen = 3'd2;
    tick();
    chk("t4_req16", 64'(req), 64'(1));
    run_burst(16, 1'b1, 0);
    chk("t4_margin_stable", 64'(margin), 64'(64 - q.size()));
    chk("t4_b2b_req", 64'(req), 64'(1));
    run_burst(16, 1'b0, 0);
    chk("t4_b2b_req2", 64'(req), 64'(1));

    // 5: flush aborts a burst at beat 10
    do_reset();
    en = 1'b1;
    pkglen = 3'd3;
    push_words(32, 1'b0);
    chk("t5_req", 64'(req), 64'(1));
    run_burst(32, 1'b0, 10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    q.delete();
    chk("t5_valid", 64'(rvalid), 64'(0));
    chk("t5_last", 64'(rlast), 64'(0));
    chk("t5_margin", 64'(margin), 64'(64));
    chk("t5_req", 64'(req), 64'(0));
    chk("t5_data", 64'(rdata), 64'(0));
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    chk("t5_stray_ack", 64'(rvalid), 64'(0));
    chk("t5_last2", 64'(rlast), 64'(0));

    // 6: reset mid-burst, then disabled channel holding 40 words
    push_words(40, 1'b0);
    chk("t6_req", 64'(req), 64'(1));
    run_burst(32, 1'b0, 5);
    do_reset();
    en = 1'b1;
    pkglen = 3'd4;
    push_words(40, 1'b0);
    chk("t6_noreq64", 64'(req), 64'(0));
    en = 1'b0;
    pkglen = 3'd3;
    for (int i = 0; i < 4; i++) begin
      chx_valid = 1'b1;
      chx_data = $urandom;
      #1;
      chk("t6_ready_dis", 64'(chx_ready), 64'(0));
      tick();
      chk("t6_req_dis", 64'(req), 64'(0));
    end
    chx_valid = 1'b0;
    chk("t6_margin", 64'(margin), 64'(64 - q.size()));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
